controller_reader: RTL and testbench
====================================

// Module: controller_reader
// PURPOSE
//  Polls a serial game-pad (latch/clock/data shift-register protocol) at a fixed rate.
//  Presents the debounced parallel button state on controller_data, which feeds the
//  controller_data input of mips_cpu and is memory-mapped by memory_top.
//  Sits directly upstream of the CPU memory stage; runs entirely in the CPU clk domain.
// PARAMETERS
//  CLK_DIV      4       clk cycles per half pad-clock period; must be >= 4
//  NUM_BUTTONS  8       bits shifted per frame; 2..31
//  POLL_PERIOD  100000  clk cycles from one latch rise to the next; >= 2*CLK_DIV*(NUM_BUTTONS+1)+2
// PORTS
//  clk              in   1   system clock; all logic on the rising edge
//  rst              in   1   asynchronous, active-low reset (0 = reset asserted)
//  en               in   1   global enable; 0 freezes all state and outputs
//  pad_data         in   1   serial data from the pad; asynchronous; 0 = button pressed
//  pad_latch        out  1   parallel-load strobe to the pad
//  pad_clk          out  1   shift clock to the pad
//  controller_data  out  32  bit i = button i pressed; bits [31:NUM_BUTTONS] = 0
//  valid            out  1   one-cycle pulse when controller_data updates
//  new_press        out  NUM_BUTTONS  buttons 0->1 since the previous frame; valid with valid
// BEHAVIOUR
//  Reset (rst=0, async):
//   - pad_latch=0, pad_clk=0, controller_data=0, valid=0, new_press=0.
//   - Synchroniser=1 (released); FSM=IDLE; poll timer=0.
//  Input sync: pad_data passes through 2 flops before use; all samples read the synced value.
//  FSM states: IDLE, LATCH, SHIFT_HI, SHIFT_LO, DONE.
//   - IDLE: poll timer counts down. At 0, reload POLL_PERIOD-1 and go to LATCH.
//     The first LATCH begins the first enabled cycle after reset release.
//   - LATCH: pad_latch=1 for 2*CLK_DIV cycles. On its last cycle, sample bit 0 and bit_idx=1.
//     The poll timer keeps counting down in every non-IDLE state.
//   - SHIFT_HI: pad_clk=1 for CLK_DIV cycles, then go to SHIFT_LO.
//   - SHIFT_LO: pad_clk=0 for CLK_DIV cycles. On its last cycle, sample bit[bit_idx].
//     If bit_idx==NUM_BUTTONS-1, go to DONE; else bit_idx++ and go to SHIFT_HI.
//   - DONE (1 cycle):
//     - controller_data <= {0, ~shift_reg} (active-low pad bits inverted).
//     - new_press <= ~shift_reg & ~prev.
//     - prev <= ~shift_reg.
//     - valid=1; go to IDLE.
//  Frame length: 2*CLK_DIV*NUM_BUTTONS + 1 cycles from latch rise to valid.
//   - Example: CLK_DIV=4, NUM_BUTTONS=8 gives 65 cycles.
//  Pad-clock edges: exactly NUM_BUTTONS-1 rising edges per frame.
//  valid and new_press: zero in every cycle except DONE.
//  Outputs pad_latch and pad_clk are registered (no glitches).
//  en=0: FSM, timers, shift register and sync flops all hold; all outputs hold their values.
//   - valid is forced to 0 while en=0, so a pulse is never stretched.
//  Reset mid-frame: the partial frame is discarded and controller_data clears to 0.
//   - A full new frame starts after release.
//  Overflow: bit_idx and the division counter never exceed their bounds; no wrap states exist.
// TESTING (CLK_DIV=4, NUM_BUTTONS=8, POLL_PERIOD=100; behavioural pad model:
//          shift register loaded on pad_latch, shifts on pad_clk rise)
//  1. Hold rst=0 -> pad_latch=0, pad_clk=0, controller_data=32'h0, valid=0, new_press=0.
//  2. Release rst; pad buttons {0,3} pressed (pad bits 8'b11110110 LSB-first) ->
//     - pad_latch high for 8 cycles, then 7 pad_clk pulses;
//     - valid pulses 65 cycles after latch rise;
//     - controller_data=32'h00000009, new_press=8'h09.
//  3. Next frame with only button 3 held -> controller_data=32'h8, new_press=0.
//     Following frame with buttons 0 and 3 -> new_press=8'h01.
//  4. en=0 for 20 cycles mid SHIFT_HI -> pad_clk stays 1 throughout;
//     the frame completes 20 cycles late with an identical controller_data.
//  5. rst=0 pulse during SHIFT_LO of bit 4 -> outputs clear immediately;
//     after release, the next frame reports the correct new pad state.
//  6. Free-running poll -> consecutive pad_latch rising edges are exactly 100 cycles
//     apart; valid occurs exactly once per period.

Source files
------------

// File: rtl/controller_reader.sv
// controller_reader: polls a latch/clock/data serial game-pad at a fixed rate
// and presents the debounced, active-high button state on controller_data.
// Pad data is active-low and shifted LSB first. Each frame takes
// 2*CLK_DIV*NUM_BUTTONS + 1 clk cycles from the latch rise to the valid pulse.
//
// Handshake: valid is a one-cycle, push-only pulse with no ready. controller_data
// and new_press are meaningful in the cycle where valid=1. controller_data then
// holds until the next pulse. new_press reads zero outside that cycle.
module controller_reader #(
    parameter int CLK_DIV     = 4,
    parameter int NUM_BUTTONS = 8,
    parameter int POLL_PERIOD = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   pad_data,
    output logic                   pad_latch,
    output logic                   pad_clk,
    output logic [31:0]            controller_data,
    output logic                   valid,
    output logic [NUM_BUTTONS-1:0] new_press
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int IDX_W = (NUM_BUTTONS > 2) ? $clog2(NUM_BUTTONS) : 1;
    localparam int TMR_W = $clog2(POLL_PERIOD);

    localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BUTTONS - 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t                 state;
    logic [1:0]             sync;
    logic                   pad_bit;
    logic [TMR_W-1:0]       timer;
    logic [DIV_W-1:0]       div_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [NUM_BUTTONS-1:0] shift_reg;
    logic [NUM_BUTTONS-1:0] prev;
    logic                   valid_q;
    logic [NUM_BUTTONS-1:0] new_press_q;

    // Two-flop synchroniser for the asynchronous pad line.
    // It idles at 1, the released level, and is frozen while en=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b11;
        end else if (en) begin
            sync <= {sync[0], pad_data};
        end
    end

    assign pad_bit = sync[1];

    // Frame sequencer: poll timer, latch pulse, pad clock, bit sampling, result update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            timer           <= '0;
            div_cnt         <= '0;
            bit_idx         <= '0;
            shift_reg       <= '1;
            prev            <= '0;
            pad_latch       <= 1'b0;
            pad_clk         <= 1'b0;
            controller_data <= '0;
            valid_q         <= 1'b0;
            new_press_q     <= '0;
        end else if (en) begin
            valid_q     <= 1'b0;
            new_press_q <= '0;
            // Outside IDLE the poll timer only counts down. A full frame is
            // shorter than POLL_PERIOD, so the timer never reaches 0 here.
            if (state != IDLE && timer != '0) begin
                timer <= timer - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (timer == '0) begin
                        timer     <= TMR_RELOAD;
                        div_cnt   <= '0;
                        pad_latch <= 1'b1;
                        state     <= LATCH;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                LATCH: begin
                    if (div_cnt == LATCH_LAST) begin
                        shift_reg[0] <= pad_bit;
                        bit_idx      <= IDX_W'(1);
                        div_cnt      <= '0;
                        pad_latch    <= 1'b0;
                        pad_clk      <= 1'b1;
                        state        <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt == HALF_LAST) begin
                        div_cnt <= '0;
                        pad_clk <= 1'b0;
                        state   <= SHIFT_LO;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (div_cnt == HALF_LAST) begin
                        div_cnt            <= '0;
                        shift_reg[bit_idx] <= pad_bit;
                        if (bit_idx == IDX_LAST) begin
                            state <= DONE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            pad_clk <= 1'b1;
                            state   <= SHIFT_HI;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    controller_data <= {{(32 - NUM_BUTTONS){1'b0}}, ~shift_reg};
                    new_press_q     <= ~shift_reg & ~prev;
                    prev            <= ~shift_reg;
                    valid_q         <= 1'b1;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Gating with en keeps a pulse from stretching across a stall.
    assign valid     = valid_q & en;
    assign new_press = new_press_q & {NUM_BUTTONS{en}};

endmodule

// File: tb/tb_controller_reader.sv
// tb_controller_reader: random pad states are driven through a behavioural pad.
// A reference model checks each reported frame, its timing and the poll rate.
module tb_controller_reader;

    localparam int CLK_DIV     = 4;
    localparam int NUM_BUTTONS = 8;
    localparam int POLL_PERIOD = 100;
    localparam int FRAME_LAT   = 2 * CLK_DIV * NUM_BUTTONS + 1;

    // ---------------- clock / reset ----------------
    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   en  = 1'b1;
    logic                   pad_data;
    logic                   pad_latch;
    logic                   pad_clk;
    logic [31:0]            controller_data;
    logic                   valid;
    logic [NUM_BUTTONS-1:0] new_press;

    always #5 clk = ~clk;

    controller_reader #(
        .CLK_DIV    (CLK_DIV),
        .NUM_BUTTONS(NUM_BUTTONS),
        .POLL_PERIOD(POLL_PERIOD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .pad_data       (pad_data),
        .pad_latch      (pad_latch),
        .pad_clk        (pad_clk),
        .controller_data(controller_data),
        .valid          (valid),
        .new_press      (new_press)
    );

    // ---------------- behavioural pad ----------------
    // pad_bits is active-low, bit i = button i. The pad reloads while latched
    // and shifts right, filling with 1, on each pad_clk rise.
    logic [NUM_BUTTONS-1:0] pad_bits = '1;
    logic [NUM_BUTTONS-1:0] pad_sr   = '1;
    logic                   pclk_d   = 1'b0;

    always @(posedge clk) begin
        if (pad_latch) pad_sr <= pad_bits;
        else if (pad_clk && !pclk_d) pad_sr <= {1'b1, pad_sr[NUM_BUTTONS-1:1]};
        pclk_d <= pad_clk;
    end
    assign pad_data = pad_sr[0];

    // Enabled-cycle counter since reset release. It is the time base for all latency checks.
    int cyc = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else if (en) cyc <= cyc + 1;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [NUM_BUTTONS-1:0] exp_q[$];   // pad snapshot taken at each latch rise
    int                     start_q[$]; // enabled-cycle stamp of that latch rise
    logic [NUM_BUTTONS-1:0] model_prev = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_latch = 1'b0;
    logic prev_pclk  = 1'b0;
    bit   rise_seen  = 1'b0;
    int   last_rise  = 0;
    int   valids_since = 0;
    int   pclk_rises = 0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_latch = 1'b0;
            prev_pclk  = 1'b0;
            rise_seen  = 1'b0;
        end else begin
            if (pad_latch && !prev_latch) begin
                if (rise_seen) begin
                    check("latch_spacing", 64'(cyc - last_rise), 64'(POLL_PERIOD));
                    check("valid_per_period", 64'(valids_since), 64'd1);
                end else begin
                    check("first_latch_after_reset", 64'(cyc), 64'd1);
                end
                rise_seen    = 1'b1;
                last_rise    = cyc;
                valids_since = 0;
                pclk_rises   = 0;
                exp_q.push_back(pad_bits);
                start_q.push_back(cyc);
            end
            if (!pad_latch && prev_latch)
                check("latch_width", 64'(cyc - last_rise), 64'(2 * CLK_DIV));
            if (pad_clk && !prev_pclk) pclk_rises++;
            if (valid) begin
                logic [NUM_BUTTONS-1:0] snap;
                logic [NUM_BUTTONS-1:0] pressed;
                int st;
                valids_since++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    snap    = exp_q.pop_front();
                    st      = start_q.pop_front();
                    pressed = ~snap;
                    check("controller_data", 64'(controller_data), 64'(pressed));
                    check("new_press", 64'(new_press), 64'(pressed & ~model_prev));
                    check("frame_latency", 64'(cyc - st), 64'(FRAME_LAT));
                    check("pad_clk_rises", 64'(pclk_rises), 64'(NUM_BUTTONS - 1));
                    model_prev = pressed;
                end
            end
            prev_latch = pad_latch;
            prev_pclk  = pad_clk;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!valid) check("valid_timeout", 64'd1, 64'd0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #3 rst = 1'b0;
        exp_q.delete();
        start_q.delete();
        model_prev = '0;
        #1;
        check("rst_controller_data", 64'(controller_data), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_new_press", 64'(new_press), 64'd0);
        check("rst_pad_latch", 64'(pad_latch), 64'd0);
        check("rst_pad_clk", 64'(pad_clk), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int hi_cnt;
        int falls;
        logic pc_d;

        // Reset state, with buttons 0 and 3 pressed for the first frame.
        pad_bits = 8'b1111_0110;
        reset_pulse();
        wait_valid();                 // 0x09, new_press 0x09

        pad_bits = 8'b1111_0111;      // only button 3
        wait_valid();                 // 0x08, new_press 0
        pad_bits = 8'b1111_0110;      // buttons 0 and 3
        wait_valid();                 // new_press 0x01

        // Stall for 20 cycles in the first cycle of a SHIFT_HI phase.
        n = 0;
        while (!pad_clk && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("found_shift_hi", 64'(pad_clk), 64'd1);
        en = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pad_clk && !valid) hi_cnt++;
        end
        check("pad_clk_held_while_stalled", 64'(hi_cnt), 64'd20);
        en = 1'b1;
        wait_valid();                 // identical 0x09, 20 cycles late

        // Reset pulse during the SHIFT_LO phase of bit 4.
        n = 0;
        while (!pad_latch && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("found_latch", 64'(pad_latch), 64'd1);
        falls = 0;
        pc_d  = pad_clk;
        n     = 0;
        while (falls < 4 && n < 200) begin
            @(negedge clk);
            if (!pad_clk && pc_d) falls++;
            pc_d = pad_clk;
            n++;
        end
        check("found_bit4_shift_lo", 64'(falls), 64'd4);
        pad_bits = 8'b0111_1110;      // buttons 0 and 7
        reset_pulse();
        wait_valid();                 // 0x81, new_press 0x81
        pad_bits = 8'b1111_1111;
        wait_valid();                 // 0x00

        // Free-running polling with random pads and random short stalls.
        for (int f = 0; f < 10; f++) begin
            pad_bits = NUM_BUTTONS'($urandom);
            repeat ($urandom_range(0, 80)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                en = 1'b0;
                repeat ($urandom_range(1, 15)) @(negedge clk);
                en = 1'b1;
            end
            wait_valid();
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
